// File: rtl/vga_scanout_if.sv
// Framebuffer-read / VGA-pin bundle for vga_scanout.
// master = the scanout block, slave = RAM read port + pin consumer side.
`timescale 1ns/1ps
interface vga_scanout_if #(
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 12
);
    logic               pix_en;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               vga_hs;
    logic               vga_vs;
    logic               vga_blank_n;
    logic [3:0]         vga_r;
    logic [3:0]         vga_g;
    logic [3:0]         vga_b;
    logic               frame_start;

    modport master (
        input  pix_en,
        input  fb_data,
        output fb_addr,
        output vga_hs,
        output vga_vs,
        output vga_blank_n,
        output vga_r,
        output vga_g,
        output vga_b,
        output frame_start
    );

    modport slave (
        output pix_en,
        output fb_data,
        input  fb_addr,
        input  vga_hs,
        input  vga_vs,
        input  vga_blank_n,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  frame_start
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: 640x480@60 timing generator reading a 160x120 framebuffer with
// 4x4 pixel replication. Stage 0 walks the raster and issues the RAM address;
// stage 1 (one pix_en tick later) drives sync/blank/colour aligned with the
// RAM data returned for that address.
`timescale 1ns/1ps
module vga_scanout #(
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = 160,
    parameter int ADDR_W      = 15,
    parameter int COLOR_W     = 12
) (
    input  logic          clk,
    input  logic          resetn,
    vga_scanout_if.master bus
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS_C  = H_W'(H_VIS);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(H_VIS + H_FP);
    localparam logic [H_W-1:0] HS_LAST  = H_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [H_W-1:0] H_ONE    = H_W'(1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS_C  = V_W'(V_VIS);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(V_VIS + V_FP);
    localparam logic [V_W-1:0] VS_LAST  = V_W'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [V_W-1:0] V_ONE    = V_W'(1);

    // Stage 0 state
    logic [H_W-1:0]     r_h_cnt;
    logic [V_W-1:0]     r_v_cnt;
    logic [ADDR_W-1:0]  r_fb_addr;
    logic               r_s0_hs;
    logic               r_s0_vs;
    logic               r_s0_vis;
    // Stage 1 (pin) state
    logic               r_hs;
    logic               r_vs;
    logic               r_blank_n;
    logic [COLOR_W-1:0] r_rgb;
    logic               r_frame_start;

    logic [H_W-1:0]     w_h_next;
    logic [V_W-1:0]     w_v_next;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_vis;
    logic               w_hs;
    logic               w_vs;
    logic [ADDR_W-1:0]  w_x;
    logic [ADDR_W-1:0]  w_y;
    logic [ADDR_W-1:0]  w_addr;

    // Next raster position and timing decodes of the current position
    always_comb begin
        w_h_last = (r_h_cnt == H_LAST);
        w_v_last = (r_v_cnt == V_LAST);
        w_h_next = r_h_cnt + H_ONE;
        w_v_next = r_v_cnt;
        if (w_h_last) begin
            w_h_next = {H_W{1'b0}};
            if (w_v_last) begin
                w_v_next = {V_W{1'b0}};
            end else begin
                w_v_next = r_v_cnt + V_ONE;
            end
        end else begin
            w_v_next = r_v_cnt;
        end
        w_vis = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
        w_hs  = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
        w_vs  = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));
    end

    // Stored-pixel coordinates: drop the replication bits
    assign w_x = ADDR_W'(r_h_cnt >> SCALE_SHIFT);
    assign w_y = ADDR_W'(r_v_cnt >> SCALE_SHIFT);

    // Row-major address; the 160-wide case is y*128 + y*32 + x
    generate
        if (FB_W == 160) begin : g_addr_160
            assign w_addr = (w_y << 3'd7) + (w_y << 3'd5) + w_x;
        end else begin : g_addr_gen
            assign w_addr = (w_y * ADDR_W'(FB_W)) + w_x;
        end
    endgenerate

    // Stage 0: raster counters, RAM address and pipelined timing decodes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_h_cnt   <= {H_W{1'b0}};
            r_v_cnt   <= {V_W{1'b0}};
            r_fb_addr <= {ADDR_W{1'b0}};
            r_s0_hs   <= 1'b1;
            r_s0_vs   <= 1'b1;
            r_s0_vis  <= 1'b0;
        end else if (bus.pix_en) begin
            r_h_cnt  <= w_h_next;
            r_v_cnt  <= w_v_next;
            r_s0_hs  <= w_hs;
            r_s0_vs  <= w_vs;
            r_s0_vis <= w_vis;
            // Address holds through blanking so the RAM sees no needless reads
            if (w_vis) begin
                r_fb_addr <= w_addr;
            end
        end
    end

    // Stage 1: pin outputs, colour taken from the RAM word for the previous tick
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_rgb     <= {COLOR_W{1'b0}};
        end else if (bus.pix_en) begin
            r_hs      <= r_s0_hs;
            r_vs      <= r_s0_vs;
            r_blank_n <= r_s0_vis;
            if (r_s0_vis) begin
                r_rgb <= bus.fb_data;
            end else begin
                r_rgb <= {COLOR_W{1'b0}};
            end
        end
    end

    // Single-clock pulse when the raster wraps from the last pixel of the frame
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= bus.pix_en && w_h_last && w_v_last;
        end
    end

    assign bus.fb_addr     = r_fb_addr;
    assign bus.vga_hs      = r_hs;
    assign bus.vga_vs      = r_vs;
    assign bus.vga_blank_n = r_blank_n;
    assign bus.vga_r       = r_rgb[COLOR_W-1 -: 4];
    assign bus.vga_g       = r_rgb[COLOR_W-5 -: 4];
    assign bus.vga_b       = r_rgb[3:0];
    assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance (real 640x480 timing) and a
// shrunken instance (23x15 raster) so whole frames fit in a short run.
// Both share clock, reset and a randomly spaced pix_en.
`timescale 1ns/1ps
module tb_vga_scanout;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bn;
        logic [11:0] rgb;
    } pins_t;

    // Raster geometry per instance: [0] full size, [1] shrunken
    int HV[2]  = '{640, 16};
    int HF[2]  = '{16, 2};
    int HSY[2] = '{96, 3};
    int HB[2]  = '{48, 2};
    int VV[2]  = '{480, 8};
    int VF[2]  = '{10, 2};
    int VSY[2] = '{2, 2};
    int VB[2]  = '{33, 3};
    int FBW[2] = '{160, 4};

    logic clk = 1'b0;
    logic resetn;
    logic pix_en;

    always #5 clk = ~clk;

    vga_scanout_if ifa ();
    vga_scanout_if ifb ();

    assign ifa.pix_en = pix_en;
    assign ifb.pix_en = pix_en;

    // RAM model for the full-size instance: word = low 12 address bits, 1 clk latency
    always @(posedge clk) ifa.fb_data <= ifa.fb_addr[11:0];
    // Shrunken instance sees an all-ones RAM, so blanking must force zeros
    assign ifb.fb_data = 12'hFFF;

    vga_scanout u_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifa.master)
    );

    vga_scanout #(
        .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .FB_W(4)
    ) u_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifb.master)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state
    int          n;            // pix_en ticks since reset release
    logic [14:0] exp_addr[2];
    pins_t       exp_pins[2];
    logic        exp_fs[2];

    // Observation history for the timing checks
    bit   track_en = 1'b0;
    logic prev_a_hs;
    logic prev_b_vs;
    int   q_a_fall[$];
    int   q_a_rise[$];
    int   q_b_vfall[$];
    int   q_b_vrise[$];
    int   q_b_fs[$];

    function automatic int ht(int k);
        return HV[k] + HF[k] + HSY[k] + HB[k];
    endfunction

    function automatic int vt(int k);
        return VV[k] + VF[k] + VSY[k] + VB[k];
    endfunction

    function automatic int frame(int k);
        return ht(k) * vt(k);
    endfunction

    function automatic int pix_h(int k, int idx);
        return (idx % frame(k)) % ht(k);
    endfunction

    function automatic int pix_v(int k, int idx);
        return (idx % frame(k)) / ht(k);
    endfunction

    function automatic bit pix_vis(int k, int idx);
        return (pix_h(k, idx) < HV[k]) && (pix_v(k, idx) < VV[k]);
    endfunction

    // Each stored pixel covers a 4x4 block of screen pixels
    function automatic int pix_addr(int k, int idx);
        return (pix_v(k, idx) / 4) * FBW[k] + (pix_h(k, idx) / 4);
    endfunction

    function automatic pins_t pix_pins(int k, int idx);
        pins_t p;
        int h;
        int v;
        int a;
        h    = pix_h(k, idx);
        v    = pix_v(k, idx);
        p.hs = !((h >= HV[k] + HF[k]) && (h < HV[k] + HF[k] + HSY[k]));
        p.vs = !((v >= VV[k] + VF[k]) && (v < VV[k] + VF[k] + VSY[k]));
        p.bn = pix_vis(k, idx);
        a    = pix_addr(k, idx);
        if (!p.bn)       p.rgb = 12'h000;
        else if (k == 0) p.rgb = a[11:0];
        else             p.rgb = 12'hFFF;
        return p;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int k = 0; k < 2; k++) begin
            exp_addr[k] = 15'd0;
            exp_pins[k] = {1'b1, 1'b1, 1'b0, 12'h000};
            exp_fs[k]   = 1'b0;
        end
    endtask

    task automatic model_tick();
        int a;
        for (int k = 0; k < 2; k++) begin
            if (pix_vis(k, n)) begin
                a = pix_addr(k, n);
                exp_addr[k] = a[14:0];
            end
            exp_fs[k] = ((n % frame(k)) == frame(k) - 1);
            if (n > 0) exp_pins[k] = pix_pins(k, n - 1);
        end
        n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (tick %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        chk("a_fb_addr", {17'd0, ifa.fb_addr}, {17'd0, exp_addr[0]});
        chk("a_hs",      {31'd0, ifa.vga_hs}, {31'd0, exp_pins[0].hs});
        chk("a_vs",      {31'd0, ifa.vga_vs}, {31'd0, exp_pins[0].vs});
        chk("a_blank_n", {31'd0, ifa.vga_blank_n}, {31'd0, exp_pins[0].bn});
        chk("a_rgb",     {20'd0, ifa.vga_r, ifa.vga_g, ifa.vga_b}, {20'd0, exp_pins[0].rgb});
        chk("a_frame_start", {31'd0, ifa.frame_start}, {31'd0, exp_fs[0]});
        chk("b_fb_addr", {17'd0, ifb.fb_addr}, {17'd0, exp_addr[1]});
        chk("b_hs",      {31'd0, ifb.vga_hs}, {31'd0, exp_pins[1].hs});
        chk("b_vs",      {31'd0, ifb.vga_vs}, {31'd0, exp_pins[1].vs});
        chk("b_blank_n", {31'd0, ifb.vga_blank_n}, {31'd0, exp_pins[1].bn});
        chk("b_rgb",     {20'd0, ifb.vga_r, ifb.vga_g, ifb.vga_b}, {20'd0, exp_pins[1].rgb});
        chk("b_frame_start", {31'd0, ifb.frame_start}, {31'd0, exp_fs[1]});
    endtask

    // Record sync edges / frame pulses and spot-check the address map
    task automatic track(input int t);
        if (prev_a_hs === 1'b1 && ifa.vga_hs === 1'b0) q_a_fall.push_back(t);
        if (prev_a_hs === 1'b0 && ifa.vga_hs === 1'b1) q_a_rise.push_back(t);
        if (prev_b_vs === 1'b1 && ifb.vga_vs === 1'b0) q_b_vfall.push_back(t);
        if (prev_b_vs === 1'b0 && ifb.vga_vs === 1'b1) q_b_vrise.push_back(t);
        if (ifb.frame_start === 1'b1) q_b_fs.push_back(t);
        prev_a_hs = ifa.vga_hs;
        prev_b_vs = ifb.vga_vs;
        if (t == 8)    chk("addr_8_0",     {17'd0, ifa.fb_addr}, 32'd2);
        if (t == 2403) chk("addr_3_3",     {17'd0, ifa.fb_addr}, 32'd0);
        if (t == 3204) chk("addr_4_4",     {17'd0, ifa.fb_addr}, 32'd161);
        if (t == 176)  chk("b_addr_last",  {17'd0, ifb.fb_addr}, 32'd7);
    endtask

    task automatic tick();
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        model_tick();
        check_all();
        if (track_en) track(n - 1);
        exp_fs[0] = 1'b0;
        exp_fs[1] = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    initial begin
        pix_en = 1'b0;
        resetn = 1'b1;
        #3;
        // Power-on reset
        resetn = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        check_all();

        // Free-running with random tick spacing, then reset mid-line
        for (int i = 0; i < 300; i++) begin
            tick();
            idle($urandom_range(1, 3));
        end
        resetn = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        resetn = 1'b1;

        prev_a_hs = ifa.vga_hs;
        prev_b_vs = ifb.vga_vs;
        track_en  = 1'b1;

        // Several full-size lines and many small frames, with one long stall mid-line
        for (int i = 0; i < 3210; i++) begin
            tick();
            if (i == 1000) idle(37);
            else           idle($urandom_range(1, 3));
        end

        // Line timing of the full-size raster
        chk("a_hs_fall_first", q_a_fall[0], 32'd657);
        chk("a_hs_low_len",    q_a_rise[0] - q_a_fall[0], 32'd96);
        chk("a_line_period",   q_a_fall[1] - q_a_fall[0], 32'd800);
        // Frame timing of the shrunken raster (23 x 15)
        chk("b_vs_fall_first", q_b_vfall[0], 32'd231);
        chk("b_vs_low_len",    q_b_vrise[0] - q_b_vfall[0], 32'd46);
        chk("b_fs_first",      q_b_fs[0], 32'd344);
        chk("b_fs_period",     q_b_fs[1] - q_b_fs[0], 32'd345);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
